// File: rtl/inst_fetch_unit_pkg.sv
// Shared encodings for the instruction fetch stage: FSM state codes and
// error cause codes reported on err_cause.
package inst_fetch_unit_pkg;

    localparam int unsigned STATE_LEN = 2;
    localparam int unsigned CAUSE_LEN = 2;
    localparam int unsigned TO_CNT_LEN = 8;

    typedef enum logic [STATE_LEN-1:0] {
        IF_IDLE = 2'b00,
        IF_REQ  = 2'b01,
        IF_DONE = 2'b10,
        IF_ERR  = 2'b11
    } if_state_t;

    typedef enum logic [CAUSE_LEN-1:0] {
        ERR_NONE     = 2'b00,
        ERR_MISALIGN = 2'b01,
        ERR_TIMEOUT  = 2'b10
    } err_cause_t;

endpackage

// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: request/acknowledge fetch from variable-latency
// instruction memory into an instruction register, with sticky error reporting.
module inst_fetch_unit
    import inst_fetch_unit_pkg::*;
#(
    parameter int unsigned ADDR_LEN = 32,
    parameter int unsigned DATA_LEN = 32,
    parameter int unsigned TIMEOUT  = 15
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                fetch_start,
    input  logic [ADDR_LEN-1:0] pc_in,
    output logic                imem_req,
    output logic [ADDR_LEN-1:0] imem_addr,
    input  logic                imem_ack,
    input  logic [DATA_LEN-1:0] imem_rdata,
    output logic [DATA_LEN-1:0] inst,
    output logic                inst_valid,
    output logic                busy,
    output logic                fetch_err,
    output logic [1:0]          err_cause,
    input  logic                err_clr,
    output logic [31:0]         fetch_cnt
);

    localparam logic [TO_CNT_LEN-1:0] TO_LAST = TO_CNT_LEN'(TIMEOUT - 1);

    if_state_t               state_q, state_d;
    err_cause_t              cause_q, cause_d;
    logic [TO_CNT_LEN-1:0]   to_q, to_d;
    logic                    req_d, valid_d, busy_d, err_d;
    logic [ADDR_LEN-1:0]     addr_d;
    logic [DATA_LEN-1:0]     inst_d;
    logic [31:0]             cnt_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IF_IDLE;
            cause_q    <= ERR_NONE;
            to_q       <= '0;
            imem_req   <= 1'b0;
            imem_addr  <= '0;
            inst       <= '0;
            inst_valid <= 1'b0;
            busy       <= 1'b0;
            fetch_err  <= 1'b0;
            fetch_cnt  <= '0;
        end else begin
            state_q    <= state_d;
            cause_q    <= cause_d;
            to_q       <= to_d;
            imem_req   <= req_d;
            imem_addr  <= addr_d;
            inst       <= inst_d;
            inst_valid <= valid_d;
            busy       <= busy_d;
            fetch_err  <= err_d;
            fetch_cnt  <= cnt_d;
        end
    end

    assign err_cause = cause_q;

    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        to_d    = to_q;
        req_d   = imem_req;
        addr_d  = imem_addr;
        inst_d  = inst;
        valid_d = 1'b0;
        err_d   = fetch_err;
        cnt_d   = fetch_cnt;

        case (state_q)
            IF_IDLE: begin
                if (fetch_start) begin
                    if (pc_in[1:0] == 2'b00) begin
                        addr_d  = pc_in;
                        req_d   = 1'b1;
                        to_d    = '0;
                        state_d = IF_REQ;
                    end else begin
                        err_d   = 1'b1;
                        cause_d = ERR_MISALIGN;
                        state_d = IF_ERR;
                    end
                end
            end
            // Ack is checked before the timeout so a response on the final
            // allowed cycle still completes the fetch.
            IF_REQ: begin
                if (imem_ack) begin
                    inst_d  = imem_rdata;
                    req_d   = 1'b0;
                    valid_d = 1'b1;
                    cnt_d   = fetch_cnt + 32'd1;
                    state_d = IF_DONE;
                end else if (to_q == TO_LAST) begin
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                    cause_d = ERR_TIMEOUT;
                    state_d = IF_ERR;
                end else begin
                    to_d = to_q + 1'b1;
                end
            end
            IF_DONE: state_d = IF_IDLE;
            IF_ERR: begin
                if (err_clr) begin
                    err_d   = 1'b0;
                    cause_d = ERR_NONE;
                    state_d = IF_IDLE;
                end
            end
            default: state_d = IF_IDLE;
        endcase

        busy_d = (state_d == IF_REQ) || (state_d == IF_DONE);
    end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Self-checking bench for inst_fetch_unit: directed vector table, hand-written
// corner sequences and randomized transactions against a transaction-level model.
module tb_inst_fetch_unit;

    localparam int unsigned TO = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_start;
    logic [31:0] pc_in;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] inst;
    logic        inst_valid;
    logic        busy;
    logic        fetch_err;
    logic [1:0]  err_cause;
    logic        err_clr;
    logic [31:0] fetch_cnt;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int last_valid_cyc = 0;

    inst_fetch_unit #(
        .ADDR_LEN(32),
        .DATA_LEN(32),
        .TIMEOUT (TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .fetch_start(fetch_start),
        .pc_in      (pc_in),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .inst       (inst),
        .inst_valid (inst_valid),
        .busy       (busy),
        .fetch_err  (fetch_err),
        .err_cause  (err_cause),
        .err_clr    (err_clr),
        .fetch_cnt  (fetch_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One fetch transaction. dly = REQ cycle (1-based) in which ack is driven;
    // 0 or > TO means no ack within the window. Expected results are supplied.
    task automatic run_txn(input logic [31:0] pc, input int unsigned dly, input logic [31:0] rd,
                           input bit noise, input logic [1:0] ecause,
                           input logic [31:0] einst, input logic [31:0] ecnt);
        int unsigned n;
        bit done;
        fetch_start = 1'b1;
        pc_in = pc;
        tick();
        fetch_start = 1'b0;
        pc_in = $urandom;
        if (ecause == 2'b01) begin
            chk("mis_req", {31'd0, imem_req}, 32'd0);
            chk("mis_busy", {31'd0, busy}, 32'd0);
        end else begin
            chk("req_up", {31'd0, imem_req}, 32'd1);
            chk("req_addr", imem_addr, pc);
            chk("req_busy", {31'd0, busy}, 32'd1);
            n = 1;
            done = 1'b0;
            while (!done) begin
                fetch_start = noise;
                pc_in = $urandom;
                imem_ack = (n == dly);
                imem_rdata = (n == dly) ? rd : $urandom;
                tick();
                imem_ack = 1'b0;
                fetch_start = 1'b0;
                if (n == dly || n == TO) begin
                    done = 1'b1;
                end else begin
                    chk("req_hold", {31'd0, imem_req}, 32'd1);
                    chk("addr_hold", imem_addr, pc);
                    chk("no_valid", {31'd0, inst_valid}, 32'd0);
                end
                n++;
            end
        end

        if (ecause == 2'b00) begin
            chk("ok_valid", {31'd0, inst_valid}, 32'd1);
            chk("ok_inst", inst, einst);
            chk("ok_cnt", fetch_cnt, ecnt);
            chk("ok_req_drop", {31'd0, imem_req}, 32'd0);
            chk("ok_busy_done", {31'd0, busy}, 32'd1);
            last_valid_cyc = cyc;
            tick();
            chk("ok_valid_pulse", {31'd0, inst_valid}, 32'd0);
            chk("ok_busy_idle", {31'd0, busy}, 32'd0);
            chk("ok_no_err", {31'd0, fetch_err}, 32'd0);
        end else begin
            chk("err_flag", {31'd0, fetch_err}, 32'd1);
            chk("err_cause", {30'd0, err_cause}, {30'd0, ecause});
            chk("err_req", {31'd0, imem_req}, 32'd0);
            chk("err_inst", inst, einst);
            chk("err_cnt", fetch_cnt, ecnt);
            chk("err_valid", {31'd0, inst_valid}, 32'd0);
            // ERR ignores fetch_start
            fetch_start = 1'b1;
            pc_in = 32'h0000_0800;
            tick();
            chk("err_sticky", {31'd0, fetch_err}, 32'd1);
            chk("err_no_req", {31'd0, imem_req}, 32'd0);
            // err_clr with fetch_start: clear only, start dropped
            err_clr = 1'b1;
            tick();
            err_clr = 1'b0;
            fetch_start = 1'b0;
            chk("clr_flag", {31'd0, fetch_err}, 32'd0);
            chk("clr_cause", {30'd0, err_cause}, 32'd0);
            chk("clr_dropped", {31'd0, imem_req}, 32'd0);
            chk("clr_busy", {31'd0, busy}, 32'd0);
        end
    endtask

    typedef struct {
        logic [31:0] pc;
        int unsigned dly;
        logic [31:0] rd;
        bit          noise;
        logic [1:0]  cause;
        logic [31:0] inst;
        logic [31:0] cnt;
    } vec_t;

    vec_t vecs[8];

    logic [31:0] m_inst;
    logic [31:0] m_cnt;

    initial begin
        vecs[0] = '{32'h0000_0040, 1,      32'h8C22_0004, 1'b0, 2'b00, 32'h8C22_0004, 32'd1};
        vecs[1] = '{32'h0000_0100, 5,      32'h1111_1111, 1'b1, 2'b00, 32'h1111_1111, 32'd2};
        vecs[2] = '{32'h0000_0042, 0,      32'h0,         1'b0, 2'b01, 32'h1111_1111, 32'd2};
        vecs[3] = '{32'h0000_0200, 1,      32'h2222_2222, 1'b0, 2'b00, 32'h2222_2222, 32'd3};
        vecs[4] = '{32'h0000_0300, 0,      32'h3333_3333, 1'b0, 2'b10, 32'h2222_2222, 32'd3};
        vecs[5] = '{32'h0000_0304, TO,     32'h4444_4444, 1'b1, 2'b00, 32'h4444_4444, 32'd4};
        vecs[6] = '{32'h0000_0303, 0,      32'h0,         1'b0, 2'b01, 32'h4444_4444, 32'd4};
        vecs[7] = '{32'h0000_0308, TO + 1, 32'h5555_5555, 1'b0, 2'b10, 32'h4444_4444, 32'd4};

        rst = 1'b0;
        fetch_start = 1'b0;
        pc_in = '0;
        imem_ack = 1'b0;
        imem_rdata = '0;
        err_clr = 1'b0;
        repeat (3) tick();
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_addr", imem_addr, 32'd0);
        chk("rst_inst", inst, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_err", {29'd0, fetch_err, err_cause}, 32'd0);
        chk("rst_cnt", fetch_cnt, 32'd0);
        rst = 1'b1;
        tick();

        // ack while idle and err_clr outside ERR have no effect
        imem_ack = 1'b1;
        imem_rdata = 32'hBAD0_BAD0;
        err_clr = 1'b1;
        tick();
        imem_ack = 1'b0;
        err_clr = 1'b0;
        chk("idle_ack_valid", {31'd0, inst_valid}, 32'd0);
        chk("idle_ack_inst", inst, 32'd0);
        chk("idle_clr_busy", {31'd0, busy}, 32'd0);

        for (int i = 0; i < 8; i++)
            run_txn(vecs[i].pc, vecs[i].dly, vecs[i].rd, vecs[i].noise,
                    vecs[i].cause, vecs[i].inst, vecs[i].cnt);

        m_inst = 32'h4444_4444;
        m_cnt = 32'd4;

        // back-to-back zero-wait fetches: valid every 3 cycles
        begin
            int prev;
            for (int i = 0; i < 3; i++) begin
                prev = last_valid_cyc;
                m_inst = 32'hA000_0000 + i;
                m_cnt = m_cnt + 1;
                run_txn(32'h0000_1000 + 4 * i, 1, m_inst, 1'b0, 2'b00, m_inst, m_cnt);
                if (i > 0) chk("b2b_spacing", last_valid_cyc - prev, 32'd3);
            end
        end

        // randomized transactions against the transaction-level model
        for (int i = 0; i < 40; i++) begin
            logic [31:0] pc;
            logic [31:0] rd;
            int unsigned dly;
            logic [1:0] cause;
            pc = $urandom;
            if ($urandom_range(0, 3) != 0) pc[1:0] = 2'b00;
            dly = $urandom_range(0, TO + 2);
            rd = $urandom;
            if (pc[1:0] != 2'b00) begin
                cause = 2'b01;
            end else if (dly >= 1 && dly <= TO) begin
                cause = 2'b00;
                m_inst = rd;
                m_cnt = m_cnt + 1;
            end else begin
                cause = 2'b10;
            end
            run_txn(pc, dly, rd, $urandom_range(0, 1) == 1, cause, m_inst, m_cnt);
        end

        // reset mid-fetch aborts immediately; late ack ignored
        fetch_start = 1'b1;
        pc_in = 32'h0000_0500;
        tick();
        fetch_start = 1'b0;
        chk("mid_req_up", {31'd0, imem_req}, 32'd1);
        rst = 1'b0;
        #1;
        chk("mid_rst_req", {31'd0, imem_req}, 32'd0);
        chk("mid_rst_inst", inst, 32'd0);
        chk("mid_rst_cnt", fetch_cnt, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        #2;
        rst = 1'b1;
        tick();
        imem_ack = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        tick();
        imem_ack = 1'b0;
        chk("late_ack_valid", {31'd0, inst_valid}, 32'd0);
        chk("late_ack_inst", inst, 32'd0);
        chk("late_ack_req", {31'd0, imem_req}, 32'd0);
        tick();
        chk("late_ack_valid2", {31'd0, inst_valid}, 32'd0);
        chk("late_ack_cnt", fetch_cnt, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
